// File: rtl/rbm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rbm_pkg
//  Description : Shared types and the Bernoulli draw rule for the RBM sampler
//                datapath (hidden- and visible-layer samplers).
//  Revision    : 1.0 - initial release
// ============================================================================
package rbm_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } sampler_state_t;

    // Probabilities are unsigned fractions: value / 2^BITLENGTH.
    localparam int DEFAULT_BITLENGTH = 8;
    localparam int CMP_W             = 32;

    // Operands are zero-extended to CMP_W; half is 2^(BITLENGTH-1), i.e. 0.5.
    function automatic logic bernoulli_draw(
        input logic [CMP_W-1:0] rnd,
        input logic [CMP_W-1:0] prob,
        input logic [CMP_W-1:0] half,
        input logic             mean_field
    );
        logic s;
        if (mean_field) begin
            s = (prob >= half);
        end else begin
            s = (rnd < prob);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bernoulli_compare.sv
`default_nettype none
// ============================================================================
//  Module      : bernoulli_compare
//  Description : Combinational single Bernoulli draw from a random word and
//                an activation probability (stochastic or mean-field).
//  Revision    : 1.0 - initial release
// ============================================================================
module bernoulli_compare
    import rbm_pkg::*;
#(
    parameter int BITLENGTH = 8
) (
    input  logic [BITLENGTH-1:0] rand_in,
    input  logic [BITLENGTH-1:0] prob_data,
    input  logic                 mean_field,
    output logic                 sample
);

    localparam logic [CMP_W-1:0] c_HALF = CMP_W'(1) << (BITLENGTH - 1);

    logic [CMP_W-1:0] w_rand_ext;
    logic [CMP_W-1:0] w_prob_ext;

    assign w_rand_ext = CMP_W'(rand_in);
    assign w_prob_ext = CMP_W'(prob_data);
    assign sample     = bernoulli_draw(w_rand_ext, w_prob_ext, c_HALF, mean_field);

endmodule
`default_nettype wire

// File: rtl/bernoulli_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : bernoulli_sampler
//  Description : Packs NUM_UNITS Bernoulli samples into a state vector and
//                hands it downstream over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bernoulli_sampler
    import rbm_pkg::*;
#(
    parameter int BITLENGTH = 8,
    parameter int NUM_UNITS = 16,
    parameter int CNT_W     = $clog2(NUM_UNITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITLENGTH-1:0] rand_in,
    input  logic                 prob_valid,
    output logic                 prob_ready,
    input  logic [BITLENGTH-1:0] prob_data,
    input  logic                 prob_last,
    input  logic                 mean_field,
    output logic                 state_valid,
    input  logic                 state_ready,
    output logic [NUM_UNITS-1:0] state_vec,
    output logic [CNT_W-1:0]     ones_count,
    output logic                 short_vec
);

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_UNITS - 1);

    sampler_state_t       r_state;
    sampler_state_t       w_state_next;
    logic [CNT_W-1:0]     r_idx;
    logic [NUM_UNITS-1:0] r_vec;
    logic [CNT_W-1:0]     r_ones;
    logic                 r_short;

    logic                 w_sample;
    logic                 w_accept;
    logic                 w_last_slot;
    logic                 w_close;
    logic                 w_release;
    logic [NUM_UNITS-1:0] w_slot;

    bernoulli_compare #(
        .BITLENGTH (BITLENGTH)
    ) u_compare (
        .rand_in    (rand_in),
        .prob_data  (prob_data),
        .mean_field (mean_field),
        .sample     (w_sample)
    );

    assign prob_ready  = (r_state == COLLECT);
    assign state_valid = (r_state == DONE);
    assign state_vec   = r_vec;
    assign ones_count  = r_ones;
    assign short_vec   = r_short;

    assign w_accept    = prob_valid & prob_ready;
    assign w_last_slot = (r_idx == c_LAST_IDX);
    assign w_close     = w_accept & (w_last_slot | prob_last);
    assign w_release   = state_valid & state_ready;

    // One-hot slot select for the bit addressed by the current index.
    always_comb begin
        w_slot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_slot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_close)   w_state_next = DONE;
            DONE:    if (w_release) w_state_next = COLLECT;
            default:                w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_vec   <= '0;
            r_ones  <= '0;
            r_short <= 1'b0;
        end else if (w_accept) begin
            r_vec  <= (r_vec & ~w_slot) | (w_sample ? w_slot : '0);
            r_ones <= r_ones + CNT_W'(w_sample);
            r_idx  <= r_idx + CNT_W'(1);
            if (w_close) begin
                r_short <= ~w_last_slot;
            end
        end else if (w_release) begin
            // Clear on release so a following short vector leaves upper bits 0.
            r_idx   <= '0;
            r_vec   <= '0;
            r_ones  <= '0;
            r_short <= 1'b0;
        end
    end

endmodule
`default_nettype wire
